// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_pkg
// Brief    : Shared fetch-state encoding, reset defaults and PC helpers.
//            Optional feature macro: FETCH_ADEL_EN (adds HALT state).
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1
`ifdef FETCH_ADEL_EN
        ,
        ST_HALT = 2'd2
`endif
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit_if
// Brief    : SRAM fetch port, IF/ID boundary and redirect signals.
//            Optional feature macro: FETCH_ADEL_EN (adds id_adel).
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if;

    logic [31:0] inst_vaddr;
    logic        inst_ce;
    logic [31:0] inst_data;
    logic        base_conflict;
    logic        id_stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
`ifdef FETCH_ADEL_EN
    logic        id_adel;
`endif

    // Fetch unit side
    modport master (
`ifdef FETCH_ADEL_EN
        output id_adel,
`endif
        output inst_vaddr,
        output inst_ce,
        output id_pc,
        output id_inst,
        output id_valid,
        input  inst_data,
        input  base_conflict,
        input  id_stall,
        input  branch_flag,
        input  branch_target,
        input  flush,
        input  flush_pc
    );

    // SRAM controller / decode / exception side
    modport slave (
`ifdef FETCH_ADEL_EN
        input  id_adel,
`endif
        input  inst_vaddr,
        input  inst_ce,
        input  id_pc,
        input  id_inst,
        input  id_valid,
        output inst_data,
        output base_conflict,
        output id_stall,
        output branch_flag,
        output branch_target,
        output flush,
        output flush_pc
    );

endinterface : inst_fetch_unit_if
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Brief    : IF stage: owns the PC, fetches from async SRAM, fills IF/ID and
//            keeps branch delay slots intact across base-RAM conflict bubbles.
//            Optional feature macro: FETCH_ADEL_EN (misaligned-PC trap).
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_unit_if.master  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_inst_q, id_inst_d;
    logic         id_valid_q, id_valid_d;
    logic         ce_q, ce_d;
    logic         inst_ce;
    logic         fetch_ok;
    logic [31:0]  seq_pc;
`ifdef FETCH_ADEL_EN
    logic         adel_q, adel_d;
    logic         misaligned;
`endif

    // A misaligned PC suppresses the SRAM access in the very cycle it is seen.
`ifdef FETCH_ADEL_EN
    always_comb begin
        misaligned = (state_q != ST_HALT) && !bus.id_stall && pc_misaligned(pc_q);
        inst_ce    = ce_q & ~misaligned;
    end
`else
    always_comb begin
        inst_ce = ce_q;
    end
`endif

    always_comb begin
        fetch_ok = inst_ce & ~bus.base_conflict;
        seq_pc   = next_seq_pc(pc_q);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        ce_d       = 1'b1;
`ifdef FETCH_ADEL_EN
        adel_d     = adel_q;
`endif

        if (bus.flush) begin
            pc_d       = bus.flush_pc;
            state_d    = ST_RUN;
            pend_d     = '0;
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
`ifdef FETCH_ADEL_EN
            adel_d     = 1'b0;
`endif
        end else if (!bus.id_stall) begin
`ifdef FETCH_ADEL_EN
            adel_d = 1'b0;
`endif
            case (state_q)
                ST_RUN, ST_PEND: begin
`ifdef FETCH_ADEL_EN
                    if (misaligned) begin
                        id_valid_d = 1'b1;
                        id_inst_d  = NOP_INST;
                        id_pc_d    = pc_q;
                        adel_d     = 1'b1;
                        state_d    = ST_HALT;
                    end else
`endif
                    if (fetch_ok) begin
                        id_pc_d    = pc_q;
                        id_inst_d  = bus.inst_data;
                        id_valid_d = 1'b1;
                        // In PEND the owed delay slot is what just issued, so redirect now.
                        if (state_q == ST_PEND) begin
                            pc_d    = pend_q;
                            state_d = ST_RUN;
                        end else begin
                            pc_d = bus.branch_flag ? bus.branch_target : seq_pc;
                        end
                    end else begin
                        id_valid_d = 1'b0;
                        id_inst_d  = NOP_INST;
                        if ((state_q == ST_RUN) && bus.branch_flag) begin
                            pend_d  = bus.branch_target;
                            state_d = ST_PEND;
                        end
                    end
                end
`ifdef FETCH_ADEL_EN
                ST_HALT: begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
`endif
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            ce_q       <= 1'b0;
`ifdef FETCH_ADEL_EN
            adel_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            ce_q       <= ce_d;
`ifdef FETCH_ADEL_EN
            adel_q     <= adel_d;
`endif
        end
    end

    assign bus.inst_vaddr = pc_q;
    assign bus.inst_ce    = inst_ce;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_inst    = id_inst_q;
    assign bus.id_valid   = id_valid_q;
`ifdef FETCH_ADEL_EN
    assign bus.id_adel    = adel_q;
`endif

endmodule : inst_fetch_unit
`default_nettype wire
